// File: rtl/coreir_cmp_stream_if.sv
// Operand/result stream bundle for coreir_cmp_stream.
// The master side produces operands and consumes results.
interface coreir_cmp_stream_if #(
    parameter int WIDTH   = 4,
    parameter int LANES   = 1,
    parameter int COUNT_W = 8
);
    logic [LANES*WIDTH-1:0] I0;
    logic [LANES*WIDTH-1:0] I1;
    logic [2:0]             OP;
    logic                   SIGNED;
    logic                   I_VALID;
    logic                   I_READY;
    logic [LANES-1:0]       O;
    logic                   O_VALID;
    logic                   O_READY;
    logic                   CLR;
    logic [COUNT_W-1:0]     COUNT;
    logic                   ERR;

    modport master (
        output I0, I1, OP, SIGNED, I_VALID, O_READY, CLR,
        input  I_READY, O, O_VALID, COUNT, ERR
    );

    modport slave (
        input  I0, I1, OP, SIGNED, I_VALID, O_READY, CLR,
        output I_READY, O, O_VALID, COUNT, ERR
    );
endinterface

// File: rtl/coreir_cmp_stream.sv
// Multi-lane streaming comparator: two-stage valid/ready pipeline with
// a saturating all-lanes-true counter and a sticky illegal-op flag.
module coreir_cmp_stream #(
    parameter int WIDTH   = 4,
    parameter int LANES   = 1,
    parameter int COUNT_W = 8
) (
    input logic                 CLK,
    input logic                 RESETN,
    coreir_cmp_stream_if.slave  bus
);

    logic [LANES*WIDTH-1:0] s1_a_q,   s1_a_d;
    logic [LANES*WIDTH-1:0] s1_b_q,   s1_b_d;
    logic [2:0]             s1_op_q,  s1_op_d;
    logic                   s1_sgn_q, s1_sgn_d;
    logic                   s1_v_q,   s1_v_d;
    logic                   s2_v_q,   s2_v_d;
    logic [LANES-1:0]       o_q,      o_d;
    logic [COUNT_W-1:0]     cnt_q,    cnt_d;
    logic                   err_q,    err_d;

    logic                   s2_load;
    logic                   in_xfer;
    logic                   out_xfer;
    logic                   illegal;
    logic [LANES-1:0]       cmp;

    // Sign-extend by one bit so a single signed compare covers both modes.
    function automatic logic lane_cmp(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [2:0]       op,
        input logic             sgn
    );
        logic [WIDTH:0] ax;
        logic [WIDTH:0] bx;
        logic           eq;
        logic           lt;
        logic           r;
        ax = {sgn & a[WIDTH-1], a};
        bx = {sgn & b[WIDTH-1], b};
        eq = (a == b);
        lt = ($signed(ax) < $signed(bx));
        unique case (op)
            3'd0:    r = eq;
            3'd1:    r = !eq;
            3'd2:    r = lt;
            3'd3:    r = lt | eq;
            3'd4:    r = !(lt | eq);
            3'd5:    r = !lt;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign s2_load     = s1_v_q & (!s2_v_q | bus.O_READY);
    assign bus.I_READY = !s1_v_q | s2_load;
    assign in_xfer     = bus.I_VALID & bus.I_READY;
    assign out_xfer    = s2_v_q & bus.O_READY;
    assign illegal     = s1_op_q[2] & s1_op_q[1];

    always_comb begin
        cmp = '0;
        for (int k = 0; k < LANES; k++) begin
            cmp[k] = lane_cmp(s1_a_q[k*WIDTH +: WIDTH],
                              s1_b_q[k*WIDTH +: WIDTH],
                              s1_op_q, s1_sgn_q);
        end
    end

    always_comb begin
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s1_op_d  = s1_op_q;
        s1_sgn_d = s1_sgn_q;
        s1_v_d   = s1_v_q;
        if (in_xfer) begin
            s1_a_d   = bus.I0;
            s1_b_d   = bus.I1;
            s1_op_d  = bus.OP;
            s1_sgn_d = bus.SIGNED;
            s1_v_d   = 1'b1;
        end else if (s2_load) begin
            s1_v_d   = 1'b0;
        end
    end

    // O is forced to zero whenever the output stage empties.
    always_comb begin
        s2_v_d = s2_v_q;
        o_d    = o_q;
        if (s2_load) begin
            s2_v_d = 1'b1;
            o_d    = cmp;
        end else if (out_xfer) begin
            s2_v_d = 1'b0;
            o_d    = '0;
        end
    end

    // Clear beats increment; a same-cycle illegal op beats clear.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.CLR) begin
            cnt_d = '0;
        end else if (out_xfer && (&o_q) && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
        err_d = (err_q & !bus.CLR) | (s2_load & illegal);
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_op_q  <= '0;
            s1_sgn_q <= 1'b0;
            s1_v_q   <= 1'b0;
            s2_v_q   <= 1'b0;
            o_q      <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_op_q  <= s1_op_d;
            s1_sgn_q <= s1_sgn_d;
            s1_v_q   <= s1_v_d;
            s2_v_q   <= s2_v_d;
            o_q      <= o_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign bus.O       = o_q;
    assign bus.O_VALID = s2_v_q;
    assign bus.COUNT   = cnt_q;
    assign bus.ERR     = err_q;

endmodule

// File: tb/tb_coreir_cmp_stream.sv
// Directed bench for coreir_cmp_stream with WIDTH=4, LANES=2, COUNT_W=2.
// Vector table for compare results plus hand sequences for pipeline corners.
module tb_coreir_cmp_stream;

    logic clk;
    logic rstn;
    int   n_chk;
    int   n_fail;

    typedef struct {
        logic [7:0] i0;
        logic [7:0] i1;
        logic [2:0] op;
        logic       sgn;
        logic [1:0] exp;
    } vec_t;

    localparam int NV = 12;
    vec_t tbl [NV];
    vec_t v_t;
    vec_t v_ill7;
    vec_t v_ill6;

    coreir_cmp_stream_if #(.WIDTH(4), .LANES(2), .COUNT_W(2)) bus ();

    coreir_cmp_stream #(.WIDTH(4), .LANES(2), .COUNT_W(2)) dut (
        .CLK    (clk),
        .RESETN (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.I0      = v.i0;
        bus.I1      = v.i1;
        bus.OP      = v.op;
        bus.SIGNED  = v.sgn;
        bus.I_VALID = 1'b1;
    endtask

    initial begin
        int in_i;
        int out_i;
        n_chk  = 0;
        n_fail = 0;

        tbl[0]  = '{8'h0F, 8'h00, 3'd3, 1'b1, 2'b11};
        tbl[1]  = '{8'h0F, 8'h00, 3'd3, 1'b0, 2'b10};
        tbl[2]  = '{8'h53, 8'h73, 3'd0, 1'b0, 2'b01};
        tbl[3]  = '{8'h53, 8'h73, 3'd1, 1'b0, 2'b10};
        tbl[4]  = '{8'h53, 8'h73, 3'd2, 1'b0, 2'b10};
        tbl[5]  = '{8'h53, 8'h73, 3'd3, 1'b0, 2'b11};
        tbl[6]  = '{8'h53, 8'h73, 3'd4, 1'b0, 2'b00};
        tbl[7]  = '{8'h53, 8'h73, 3'd5, 1'b0, 2'b01};
        tbl[8]  = '{8'h78, 8'h87, 3'd2, 1'b1, 2'b01};
        tbl[9]  = '{8'h78, 8'h87, 3'd2, 1'b0, 2'b10};
        tbl[10] = '{8'hF0, 8'h0F, 3'd5, 1'b1, 2'b01};
        tbl[11] = '{8'hAA, 8'hAA, 3'd0, 1'b1, 2'b11};
        v_t     = '{8'h33, 8'h33, 3'd0, 1'b0, 2'b11};
        v_ill7  = '{8'h33, 8'h33, 3'd7, 1'b0, 2'b00};
        v_ill6  = '{8'h33, 8'h33, 3'd6, 1'b0, 2'b00};

        rstn        = 1'b0;
        bus.I0      = '0;
        bus.I1      = '0;
        bus.OP      = '0;
        bus.SIGNED  = 1'b0;
        bus.I_VALID = 1'b0;
        bus.O_READY = 1'b1;
        bus.CLR     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ovalid", bus.O_VALID, 0);
        chk("rst_o",      bus.O,       0);
        chk("rst_count",  bus.COUNT,   0);
        chk("rst_err",    bus.ERR,     0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_iready", bus.I_READY, 1);

        // Back-to-back table stream; vector j visible two negedges later.
        for (int c = 0; c < NV + 2; c++) begin
            @(negedge clk);
            if (c == 1) chk("lat_early", bus.O_VALID, 0);
            if (c >= 2) begin
                chk("tbl_ovalid", bus.O_VALID, 1);
                chk($sformatf("tbl_o[%0d]", c - 2), bus.O, tbl[c-2].exp);
            end
            if (c < NV) drive(tbl[c]);
            else        bus.I_VALID = 1'b0;
            #1;
            if (c < NV) chk("tbl_iready", bus.I_READY, 1);
        end

        // Backpressure: 6 inputs, consumer stalled for the first 4 cycles.
        in_i  = 0;
        out_i = 0;
        for (int cyc = 0; cyc < 30 && out_i < 6; cyc++) begin
            @(negedge clk);
            bus.O_READY = (cyc >= 4);
            if (in_i < 6) drive(tbl[2+in_i]);
            else          bus.I_VALID = 1'b0;
            #1;
            if (cyc == 2 || cyc == 3) begin
                chk("bp_iready_low", bus.I_READY, 0);
                chk("bp_hold_v",     bus.O_VALID, 1);
                chk("bp_hold_o",     bus.O,       tbl[2].exp);
            end
            if (bus.O_VALID && bus.O_READY) begin
                chk($sformatf("bp_order[%0d]", out_i), bus.O, tbl[2+out_i].exp);
                out_i++;
            end
            if (bus.I_VALID && bus.I_READY) in_i++;
        end
        chk("bp_delivered", out_i, 6);
        bus.I_VALID = 1'b0;
        bus.O_READY = 1'b1;
        @(negedge clk);
        chk("bp_no_dup", bus.O_VALID, 0);

        // Saturating counter.
        bus.CLR = 1'b1;
        @(negedge clk);
        bus.CLR = 1'b0;
        chk("cnt_clr0", bus.COUNT, 0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c >= 3) chk($sformatf("cnt_seq[%0d]", c - 2), bus.COUNT,
                            (c - 2 > 3) ? 3 : c - 2);
            if (c < 5) drive(v_t);
            else       bus.I_VALID = 1'b0;
        end
        drive(v_t);
        @(negedge clk);
        bus.I_VALID = 1'b0;
        @(negedge clk);
        chk("cnt_clr_ov", bus.O_VALID, 1);
        bus.CLR = 1'b1;
        @(negedge clk);
        bus.CLR = 1'b0;
        chk("cnt_clr_wins", bus.COUNT, 0);

        // Sticky illegal-op flag.
        drive(v_ill7);
        @(negedge clk);
        bus.I_VALID = 1'b0;
        chk("err_s1_only", bus.ERR, 0);
        @(negedge clk);
        chk("err_ill_ov", bus.O_VALID, 1);
        chk("err_ill_o",  bus.O,       0);
        chk("err_set",    bus.ERR,     1);
        drive(tbl[2]);
        @(negedge clk);
        bus.I_VALID = 1'b0;
        @(negedge clk);
        chk("err_legal_o", bus.O,   tbl[2].exp);
        chk("err_sticky",  bus.ERR, 1);
        bus.CLR = 1'b1;
        @(negedge clk);
        bus.CLR = 1'b0;
        chk("err_clr", bus.ERR, 0);
        drive(v_ill6);
        @(negedge clk);
        bus.I_VALID = 1'b0;
        bus.CLR     = 1'b1;
        @(negedge clk);
        bus.CLR = 1'b0;
        chk("err_set_wins", bus.ERR, 1);

        // One all-true output so reset has a nonzero count to clear.
        drive(v_t);
        @(negedge clk);
        bus.I_VALID = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_count", bus.COUNT, 1);

        // Reset with both stages full and the consumer stalled.
        bus.O_READY = 1'b0;
        drive(v_t);
        @(negedge clk);
        drive(v_t);
        @(negedge clk);
        bus.I_VALID = 1'b0;
        #1;
        chk("mid_ovalid", bus.O_VALID, 1);
        chk("mid_iready", bus.I_READY, 0);
        rstn = 1'b0;
        @(negedge clk);
        chk("mrst_ovalid", bus.O_VALID, 0);
        chk("mrst_o",      bus.O,       0);
        chk("mrst_count",  bus.COUNT,   0);
        chk("mrst_err",    bus.ERR,     0);
        chk("mrst_iready", bus.I_READY, 1);
        rstn        = 1'b1;
        bus.O_READY = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("mrst_flushed", bus.O_VALID, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
